// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches the decode bundle into E, detects load-use hazards, inserts bubbles.
// Latency 1 cycle; stall_e holds E; load-use or flush_e loads a bubble; saturating bubble counters.
module id_ex_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_ADDR_BITS = 5,
    parameter int STAT_BITS     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_d,
    input  logic                     reg_write_d,
    input  logic [1:0]               mem_to_reg_d,
    input  logic                     mem_write_d,
    input  logic [1:0]               alu_control_d,
    input  logic                     alu_src_d,
    input  logic [1:0]               reg_dst_d,
    input  logic [5:0]               funct_d,
    input  logic [REG_ADDR_BITS-1:0] rs_d,
    input  logic [REG_ADDR_BITS-1:0] rt_d,
    input  logic [REG_ADDR_BITS-1:0] rd_d,
    input  logic [DATA_WIDTH-1:0]    rd1_d,
    input  logic [DATA_WIDTH-1:0]    rd2_d,
    input  logic [DATA_WIDTH-1:0]    sign_imm_d,
    input  logic [DATA_WIDTH-1:0]    pc_plus4_d,
    input  logic                     flush_e,
    input  logic                     stall_e,
    output logic                     stall_f,
    output logic                     stall_d,
    output logic                     valid_e,
    output logic                     reg_write_e,
    output logic [1:0]               mem_to_reg_e,
    output logic                     mem_write_e,
    output logic [1:0]               alu_control_e,
    output logic                     alu_src_e,
    output logic [1:0]               reg_dst_e,
    output logic [5:0]               funct_e,
    output logic [REG_ADDR_BITS-1:0] rs_e,
    output logic [REG_ADDR_BITS-1:0] rt_e,
    output logic [REG_ADDR_BITS-1:0] rd_e,
    output logic [DATA_WIDTH-1:0]    rd1_e,
    output logic [DATA_WIDTH-1:0]    rd2_e,
    output logic [DATA_WIDTH-1:0]    sign_imm_e,
    output logic [DATA_WIDTH-1:0]    pc_plus4_e,
    output logic [REG_ADDR_BITS-1:0] write_reg_e,
    output logic [STAT_BITS-1:0]     load_use_cnt,
    output logic [STAT_BITS-1:0]     flush_cnt
);

    typedef struct packed {
        logic                     valid;
        logic                     reg_write;
        logic [1:0]               mem_to_reg;
        logic                     mem_write;
        logic [1:0]               alu_control;
        logic                     alu_src;
        logic [1:0]               reg_dst;
        logic [5:0]               funct;
        logic [REG_ADDR_BITS-1:0] rs;
        logic [REG_ADDR_BITS-1:0] rt;
        logic [REG_ADDR_BITS-1:0] rd;
        logic [DATA_WIDTH-1:0]    rd1;
        logic [DATA_WIDTH-1:0]    rd2;
        logic [DATA_WIDTH-1:0]    sign_imm;
        logic [DATA_WIDTH-1:0]    pc_plus4;
    } ex_t;

    ex_t                  ex_q, ex_d;
    logic [STAT_BITS-1:0] load_use_cnt_q, load_use_cnt_d;
    logic [STAT_BITS-1:0] flush_cnt_q, flush_cnt_d;
    logic                 load_use;

    // A load writing $0 never creates a real dependency.
    assign load_use = ex_q.valid && ex_q.reg_write && (ex_q.mem_to_reg == 2'b01)
                   && (ex_q.rt != '0) && valid_d
                   && ((ex_q.rt == rs_d) || (ex_q.rt == rt_d));

    assign stall_f = load_use || stall_e;
    assign stall_d = load_use || stall_e;

    always_comb begin
        ex_d           = ex_q;
        load_use_cnt_d = load_use_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        if (!stall_e) begin
            if (flush_e || load_use) begin
                ex_d = '0;
                if (flush_e) begin
                    if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
                end else if (load_use_cnt_q != '1) begin
                    load_use_cnt_d = load_use_cnt_q + 1'b1;
                end
            end else if (!valid_d) begin
                ex_d = '0;
            end else begin
                ex_d = '{valid: 1'b1, reg_write: reg_write_d, mem_to_reg: mem_to_reg_d,
                         mem_write: mem_write_d, alu_control: alu_control_d,
                         alu_src: alu_src_d, reg_dst: reg_dst_d, funct: funct_d,
                         rs: rs_d, rt: rt_d, rd: rd_d, rd1: rd1_d, rd2: rd2_d,
                         sign_imm: sign_imm_d, pc_plus4: pc_plus4_d};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q           <= '0;
            load_use_cnt_q <= '0;
            flush_cnt_q    <= '0;
        end else begin
            ex_q           <= ex_d;
            load_use_cnt_q <= load_use_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    always_comb begin
        write_reg_e = '0;
        case (ex_q.reg_dst)
            2'b00:   write_reg_e = ex_q.rt;
            2'b01:   write_reg_e = ex_q.rd;
            2'b10:   write_reg_e = REG_ADDR_BITS'(31);
            default: write_reg_e = '0;
        endcase
    end

    assign valid_e       = ex_q.valid;
    assign reg_write_e   = ex_q.reg_write;
    assign mem_to_reg_e  = ex_q.mem_to_reg;
    assign mem_write_e   = ex_q.mem_write;
    assign alu_control_e = ex_q.alu_control;
    assign alu_src_e     = ex_q.alu_src;
    assign reg_dst_e     = ex_q.reg_dst;
    assign funct_e       = ex_q.funct;
    assign rs_e          = ex_q.rs;
    assign rt_e          = ex_q.rt;
    assign rd_e          = ex_q.rd;
    assign rd1_e         = ex_q.rd1;
    assign rd2_e         = ex_q.rd2;
    assign sign_imm_e    = ex_q.sign_imm;
    assign pc_plus4_e    = ex_q.pc_plus4;
    assign load_use_cnt  = load_use_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage built with 2-bit counters so saturation is reachable.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_d, reg_write_d, mem_write_d, alu_src_d, flush_e, stall_e;
    logic [1:0]  mem_to_reg_d, alu_control_d, reg_dst_d;
    logic [5:0]  funct_d;
    logic [4:0]  rs_d, rt_d, rd_d;
    logic [31:0] rd1_d, rd2_d, sign_imm_d, pc_plus4_d;
    logic        stall_f, stall_d, valid_e, reg_write_e, mem_write_e, alu_src_e;
    logic [1:0]  mem_to_reg_e, alu_control_e, reg_dst_e;
    logic [5:0]  funct_e;
    logic [4:0]  rs_e, rt_e, rd_e, write_reg_e;
    logic [31:0] rd1_e, rd2_e, sign_imm_e, pc_plus4_e;
    logic [1:0]  load_use_cnt, flush_cnt;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [4:0]  write_reg;
        logic [31:0] rd1;
        logic        stall_f;
        logic        stall_d;
        logic [1:0]  lu;
        logic [1:0]  fl;
    } obs_t;

    obs_t sb[$];
    obs_t exp_o, obs;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_BITS(5), .STAT_BITS(2)) dut (
        .clk(clk), .reset(reset), .valid_d(valid_d), .reg_write_d(reg_write_d),
        .mem_to_reg_d(mem_to_reg_d), .mem_write_d(mem_write_d), .alu_control_d(alu_control_d),
        .alu_src_d(alu_src_d), .reg_dst_d(reg_dst_d), .funct_d(funct_d),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
        .sign_imm_d(sign_imm_d), .pc_plus4_d(pc_plus4_d), .flush_e(flush_e), .stall_e(stall_e),
        .stall_f(stall_f), .stall_d(stall_d), .valid_e(valid_e), .reg_write_e(reg_write_e),
        .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e), .alu_control_e(alu_control_e),
        .alu_src_e(alu_src_e), .reg_dst_e(reg_dst_e), .funct_e(funct_e),
        .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
        .sign_imm_e(sign_imm_e), .pc_plus4_e(pc_plus4_e), .write_reg_e(write_reg_e),
        .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
    );

    function automatic obs_t sample();
        return '{valid: valid_e, reg_write: reg_write_e, write_reg: write_reg_e, rd1: rd1_e,
                 stall_f: stall_f, stall_d: stall_d, lu: load_use_cnt, fl: flush_cnt};
    endfunction

    // Expected observation; counters are 2 bits wide and saturate at 3.
    function automatic obs_t mk(logic v, logic rw, logic [4:0] wr, logic [31:0] d1,
                                logic st, int lu, int fl);
        return '{valid: v, reg_write: rw, write_reg: wr, rd1: d1, stall_f: st, stall_d: st,
                 lu: 2'((lu > 3) ? 3 : lu), fl: 2'((fl > 3) ? 3 : fl)};
    endfunction

    task automatic drive(logic v, logic rw, logic [1:0] m2r, logic [4:0] rs, logic [4:0] rt,
                         logic [4:0] rd, logic [1:0] dst, logic [31:0] d1);
        valid_d = v; reg_write_d = rw; mem_to_reg_d = m2r; mem_write_d = 1'b0;
        alu_control_d = 2'b10; alu_src_d = 1'b0; reg_dst_d = dst; funct_d = 6'h20;
        rs_d = rs; rt_d = rt; rd_d = rd; rd1_d = d1; rd2_d = ~d1;
        sign_imm_d = 32'h4; pc_plus4_d = 32'h100;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 2'b00, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush_e = 1'b0; stall_e = 1'b0;
        nop();
        tick();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; flush_e = 1'b0; stall_e = 1'b0;
        drive(1'b1, 1'b1, 2'b01, 5'd3, 5'd3, 5'd3, 2'b00, 32'hDEAD_BEEF);
        tick();
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        #1;
        exp_o = sb.pop_front(); obs = sample(); checks++;
        if (obs !== exp_o) begin failures++; $display("FAIL reset_state got=%h want=%h", obs, exp_o); end
        reset = 1'b0;
        nop();
    endtask

    task automatic test_add();
        do_reset();
        drive(1'b1, 1'b1, 2'b00, 5'd1, 5'd2, 5'd5, 2'b01, 32'h1111);
        tick();
        drive(1'b1, 1'b1, 2'b00, 5'd2, 5'd2, 5'd6, 2'b01, 32'h2222);
        sb.push_back(mk(1, 1, 5, 32'h1111, 0, 0, 0));
        #1;
        exp_o = sb.pop_front(); obs = sample(); checks++;
        if (obs !== exp_o) begin failures++; $display("FAIL add_latch got=%h want=%h", obs, exp_o); end
        tick();
        nop();
        sb.push_back(mk(1, 1, 6, 32'h2222, 0, 0, 0));
        #1;
        exp_o = sb.pop_front(); obs = sample(); checks++;
        if (obs !== exp_o) begin failures++; $display("FAIL add_dependent got=%h want=%h", obs, exp_o); end
    endtask

    task automatic test_write_reg();
        logic [4:0] want [4];
        want[0] = 5'd7; want[1] = 5'd9; want[2] = 5'd31; want[3] = 5'd0;
        do_reset();
        drive(1'b1, 1'b1, 2'b00, 5'd1, 5'd7, 5'd9, 2'b00, 32'd0);
        for (int d = 0; d < 4; d++) begin
            tick();
            if (d < 3) drive(1'b1, 1'b1, 2'b00, 5'd1, 5'd7, 5'd9, 2'(d + 1), 32'(d + 1));
            else       drive(1'b0, 1'b1, 2'b00, 5'd1, 5'd7, 5'd9, 2'b01, 32'h5);
            sb.push_back(mk(1, 1, want[d], 32'(d), 0, 0, 0));
            #1;
            exp_o = sb.pop_front(); obs = sample(); checks++;
            if (obs !== exp_o) begin failures++; $display("FAIL write_reg_dst%0d got=%h want=%h", d, obs, exp_o); end
        end
        tick();
        nop();
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        #1;
        exp_o = sb.pop_front(); obs = sample(); checks++;
        if (obs !== exp_o) begin failures++; $display("FAIL invalid_d_bubble got=%h want=%h", obs, exp_o); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 1'b1, 2'b01, 5'd3, 5'd8, 5'd0, 2'b00, 32'hAAAA);
        tick();
        drive(1'b1, 1'b1, 2'b00, 5'd8, 5'd9, 5'd10, 2'b01, 32'hBBBB);
        sb.push_back(mk(1, 1, 8, 32'hAAAA, 1, 0, 0));
        #1;
        exp_o = sb.pop_front(); obs = sample(); checks++;
        if (obs !== exp_o) begin failures++; $display("FAIL lu_detect got=%h want=%h", obs, exp_o); end
        tick();
        sb.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        #1;
        exp_o = sb.pop_front(); obs = sample(); checks++;
        if (obs !== exp_o) begin failures++; $display("FAIL lu_bubble got=%h want=%h", obs, exp_o); end
        tick();
        drive(1'b1, 1'b1, 2'b01, 5'd3, 5'd4, 5'd0, 2'b00, 32'hCCCC);
        sb.push_back(mk(1, 1, 10, 32'hBBBB, 0, 1, 0));
        #1;
        exp_o = sb.pop_front(); obs = sample(); checks++;
        if (obs !== exp_o) begin failures++; $display("FAIL lu_add_enters got=%h want=%h", obs, exp_o); end
        // Second load: the consumer matches through rt instead of rs.
        tick();
        drive(1'b1, 1'b1, 2'b00, 5'd1, 5'd4, 5'd11, 2'b01, 32'hDDDD);
        sb.push_back(mk(1, 1, 4, 32'hCCCC, 1, 1, 0));
        #1;
        exp_o = sb.pop_front(); obs = sample(); checks++;
        if (obs !== exp_o) begin failures++; $display("FAIL lu_rt_match got=%h want=%h", obs, exp_o); end
        tick();
        nop();
        sb.push_back(mk(0, 0, 0, 0, 0, 2, 0));
        #1;
        exp_o = sb.pop_front(); obs = sample(); checks++;
        if (obs !== exp_o) begin failures++; $display("FAIL lu_rt_bubble got=%h want=%h", obs, exp_o); end
    endtask

    task automatic test_load_r0();
        do_reset();
        drive(1'b1, 1'b1, 2'b01, 5'd0, 5'd0, 5'd0, 2'b00, 32'hC0C0);
        tick();
        drive(1'b1, 1'b1, 2'b00, 5'd0, 5'd0, 5'd4, 2'b01, 32'h4444);
        sb.push_back(mk(1, 1, 0, 32'hC0C0, 0, 0, 0));
        #1;
        exp_o = sb.pop_front(); obs = sample(); checks++;
        if (obs !== exp_o) begin failures++; $display("FAIL r0_no_stall got=%h want=%h", obs, exp_o); end
        tick();
        nop();
        sb.push_back(mk(1, 1, 4, 32'h4444, 0, 0, 0));
        #1;
        exp_o = sb.pop_front(); obs = sample(); checks++;
        if (obs !== exp_o) begin failures++; $display("FAIL r0_next got=%h want=%h", obs, exp_o); end
    endtask

    task automatic test_flush_and_load_use();
        do_reset();
        drive(1'b1, 1'b1, 2'b01, 5'd3, 5'd8, 5'd0, 2'b00, 32'hAAAA);
        tick();
        drive(1'b1, 1'b1, 2'b00, 5'd8, 5'd9, 5'd10, 2'b01, 32'hBBBB);
        flush_e = 1'b1;
        sb.push_back(mk(1, 1, 8, 32'hAAAA, 1, 0, 0));
        #1;
        exp_o = sb.pop_front(); obs = sample(); checks++;
        if (obs !== exp_o) begin failures++; $display("FAIL fl_lu_pre got=%h want=%h", obs, exp_o); end
        tick();
        flush_e = 1'b0;
        nop();
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        #1;
        exp_o = sb.pop_front(); obs = sample(); checks++;
        if (obs !== exp_o) begin failures++; $display("FAIL fl_lu_bubble got=%h want=%h", obs, exp_o); end
    endtask

    task automatic test_stall_e();
        do_reset();
        drive(1'b1, 1'b1, 2'b00, 5'd1, 5'd2, 5'd5, 2'b01, 32'h1);
        tick();
        drive(1'b1, 1'b1, 2'b00, 5'd1, 5'd2, 5'd6, 2'b01, 32'h2);
        stall_e = 1'b1;
        sb.push_back(mk(1, 1, 5, 32'h1, 1, 0, 0));
        #1;
        exp_o = sb.pop_front(); obs = sample(); checks++;
        if (obs !== exp_o) begin failures++; $display("FAIL stall_e_start got=%h want=%h", obs, exp_o); end
        for (int i = 1; i <= 2; i++) begin
            tick();
            drive(1'b1, 1'b1, 2'b00, 5'd1, 5'd2, 5'(6 + i), 2'b01, 32'(2 + i));
            flush_e = (i == 2);
            sb.push_back(mk(1, 1, 5, 32'h1, 1, 0, 0));
            #1;
            exp_o = sb.pop_front(); obs = sample(); checks++;
            if (obs !== exp_o) begin failures++; $display("FAIL stall_e_hold%0d got=%h want=%h", i, obs, exp_o); end
        end
        tick();
        stall_e = 1'b0;
        flush_e = 1'b0;
        drive(1'b1, 1'b1, 2'b00, 5'd1, 5'd2, 5'd20, 2'b01, 32'h7);
        sb.push_back(mk(1, 1, 5, 32'h1, 0, 0, 0));
        #1;
        exp_o = sb.pop_front(); obs = sample(); checks++;
        if (obs !== exp_o) begin failures++; $display("FAIL stall_e_flush_ignored got=%h want=%h", obs, exp_o); end
        tick();
        nop();
        sb.push_back(mk(1, 1, 20, 32'h7, 0, 0, 0));
        #1;
        exp_o = sb.pop_front(); obs = sample(); checks++;
        if (obs !== exp_o) begin failures++; $display("FAIL stall_e_release got=%h want=%h", obs, exp_o); end
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        drive(1'b1, 1'b1, 2'b00, 5'd1, 5'd2, 5'd5, 2'b01, 32'h9);
        flush_e = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tick();
            if (n == 5) begin
                flush_e = 1'b0;
                drive(1'b1, 1'b1, 2'b01, 5'd3, 5'd8, 5'd0, 2'b00, 32'hAAAA);
            end
            sb.push_back(mk(0, 0, 0, 0, 0, 0, n));
            #1;
            exp_o = sb.pop_front(); obs = sample(); checks++;
            if (obs !== exp_o) begin failures++; $display("FAIL flush_sat%0d got=%h want=%h", n, obs, exp_o); end
        end
        tick();
        drive(1'b1, 1'b1, 2'b00, 5'd8, 5'd9, 5'd10, 2'b01, 32'hBBBB);
        sb.push_back(mk(1, 1, 8, 32'hAAAA, 1, 0, 3));
        #1;
        exp_o = sb.pop_front(); obs = sample(); checks++;
        if (obs !== exp_o) begin failures++; $display("FAIL sat_then_lu got=%h want=%h", obs, exp_o); end
        reset = 1'b1;
        tick();
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        #1;
        exp_o = sb.pop_front(); obs = sample(); checks++;
        if (obs !== exp_o) begin failures++; $display("FAIL reset_mid_stall got=%h want=%h", obs, exp_o); end
        reset = 1'b0;
        nop();
    endtask

    initial begin
        test_reset();
        test_add();
        test_write_reg();
        test_load_use();
        test_load_r0();
        test_flush_and_load_use();
        test_stall_e();
        test_saturate_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX boundary of the 5-stage MIPS pipeline. It registers the decode-stage control bundle and operands into the execute stage. It detects load-use hazards and generates fetch/decode stalls. It inserts bubbles on load-use or a branch/jump flush, and keeps saturating bubble statistics for debug.

Parameters:
DATA_WIDTH, 32, operand/immediate/PC width
REG_ADDR_BITS, 5, register index width
STAT_BITS, 16, width of each statistics counter

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
valid_d  in  1  decode slot holds a real instruction
reg_write_d  in  1  decode control: register write
mem_to_reg_d  in  2  decode control: 00 ALU, 01 memory, 10 PC+4
mem_write_d  in  1  decode control: memory write
alu_control_d  in  2  decode control: ALUOp 00 add, 01 sub, 10 funct
alu_src_d  in  1  decode control: 1 = immediate operand
reg_dst_d  in  2  decode control: 00 rt, 01 rd, 10 r31
funct_d  in  6  instruction funct field
rs_d, rt_d, rd_d  in  REG_ADDR_BITS each  register indices
rd1_d, rd2_d  in  DATA_WIDTH each  register file read data
sign_imm_d  in  DATA_WIDTH  sign-extended immediate
pc_plus4_d  in  DATA_WIDTH  PC+4
flush_e  in  1  branch/jump resolved taken; kill the decode slot
stall_e  in  1  downstream (memory) stall; hold E
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID register
valid_e, reg_write_e, mem_to_reg_e, mem_write_e, alu_control_e, alu_src_e, reg_dst_e, funct_e, rs_e, rt_e, rd_e, rd1_e, rd2_e, sign_imm_e, pc_plus4_e  out  same widths as _d  registered E bundle
write_reg_e  out  REG_ADDR_BITS  destination index selected by reg_dst_e
load_use_cnt  out  STAT_BITS  number of load-use bubbles
flush_cnt  out  STAT_BITS  number of flush bubbles

Behaviour:
- Reset, synchronous, highest priority: every _e output is 0 (valid_e=0) and both counters are 0. stall_f/stall_d are combinational and therefore also 0 while E is empty.
- load_use is combinational and asserts when all of the following hold:
  - valid_e, reg_write_e, and mem_to_reg_e==01
  - rt_e != 0
  - valid_d
  - rt_e==rs_d or rt_e==rt_d
- stall_f = stall_d = load_use OR stall_e.
- Per-cycle register update, in priority order:
  1. reset: clear everything.
  2. stall_e=1: hold all E registers, counters unchanged, even if flush_e or load_use is also asserted.
  3. flush_e=1 or load_use=1: load a bubble. All E fields go to 0, so valid_e=0, reg_write_e=0, mem_write_e=0, data fields 0. Counter updates:
     - flush_e=1: flush_cnt +1.
     - flush_e=0 and load_use=1: load_use_cnt +1.
     - Both asserted: only flush_cnt increments.
  4. Otherwise: load every _d input into its _e register. A cycle with valid_d=0 loads a bubble but does not count.
- Latency: one cycle from a _d input to the matching _e output. Load-use costs exactly one bubble, because after insertion valid_e=0 and load_use deasserts.
- write_reg_e is combinational from E:
  - reg_dst_e 00: rt_e
  - 01: rd_e
  - 10: 31
  - 11: 0
- Counters saturate at 2^STAT_BITS-1; no wrap.
- Reset asserted mid-stall clears E; stalls drop the same cycle the cleared state is visible.

Test Plan:
- Reset, then an ADD bundle with valid_d=1, rd_d=5, reg_dst_d=01 -> next cycle valid_e=1, reg_write_e=1, write_reg_e=5; stall_f=stall_d=0.
- LW with rt=8 enters E; next decode is ADD with rs_d=8 -> stall_f=stall_d=1 for exactly one cycle, then a bubble (valid_e=0, reg_write_e=0), load_use_cnt=1; the ADD enters E the following cycle.
- LW with rt=0 in E, decode uses rs_d=0 -> no stall, load_use_cnt stays 0.
- flush_e=1 in the same cycle load_use=1 -> bubble, flush_cnt=1, load_use_cnt=0.
- stall_e=1 for 3 cycles while _d inputs change -> E outputs unchanged, stall_f=1 throughout; stall_e drops -> the current _d bundle is latched.
- STAT_BITS=2 with 5 flushes -> flush_cnt reads 3 and stays at 3; reset asserted mid-sequence -> counters 0 and valid_e=0 the next cycle.
